// File: rtl/divide_32.sv
// rtl/divide_32.sv - iterative unsigned restoring divider, one quotient bit per clock
module divide_32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N:0]    pr;
  logic [N-1:0]  sr;
  logic [N-1:0]  dr;
  logic [CW-1:0] cnt;

  logic [N:0]    pr_shift;
  logic [N:0]    pr_next;
  logic [N-1:0]  sr_next;
  logic          qbit;

  // One restoring step; the N+1-bit partial remainder makes the subtract overflow-free.
  always_comb begin
    pr_shift = {pr[N-1:0], sr[N-1]};
    qbit     = (pr_shift >= {1'b0, dr});
    pr_next  = qbit ? (pr_shift - {1'b0, dr}) : pr_shift;
    sr_next  = {sr[N-2:0], qbit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      pr          <= '0;
      sr          <= '0;
      dr          <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (enable) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
              state       <= DONE;
            end else begin
              sr    <= dividend;
              dr    <= divisor;
              pr    <= '0;
              cnt   <= CW'(N);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          pr  <= pr_next;
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          // Last iteration: publish straight from the step result.
          if (cnt == CW'(1)) begin
            quotient    <= sr_next;
            remainder   <= pr_next[N-1:0];
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (!enable) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/divide_32.md
Name: divide_32

Overview:
- Iterative unsigned divider: the inverse operation to the team's sequential multiply_32 unit.
- Uses the same enable/ready handshake style and the same N-bit operand width.
- Computes quotient and remainder by restoring shift-subtract, one quotient bit per clock.
- Sits beside multiply_32 in the execution unit and is started by the same control logic.

Parameters:
N, 32, operand width in bits (dividend, divisor, quotient, remainder)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
enable  input  1  level start request; sampled in IDLE
dividend  input  N  unsigned dividend; latched at start
divisor  input  N  unsigned divisor; latched at start
ready  output  1  high while result is valid (DONE state)
quotient  output  N  unsigned quotient
remainder  output  N  unsigned remainder
div_by_zero  output  1  high with ready when the latched divisor was 0

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset forces the following, regardless of the current state:
  - state=IDLE, ready=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers (partial remainder, shift register, counter) = 0.
- Reset mid-operation aborts the division; no partial result is ever presented.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE, enable=0: hold; outputs keep their last values; ready=0.
- IDLE, enable=1 at edge k, divisor!=0:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (N+1 bits); load counter=N.
  - Go to BUSY.
- IDLE, enable=1 at edge k, divisor==0:
  - Go directly to DONE at edge k.
  - quotient={N{1'b1}}, remainder=dividend, div_by_zero=1.
  - ready=1 from edge k.
- BUSY, each edge performs one iteration:
  - pr' = {pr[N-1:0], sr[N-1]}.
  - If pr' >= divisor: pr' = pr' - divisor and the quotient bit is 1; otherwise the bit is 0.
  - sr = {sr[N-2:0], qbit}; counter decrements.
  - The subtract is N+1 bits wide; no overflow is possible.
- BUSY, final edge (counter reaches 0, i.e. edge k+N):
  - quotient=sr, remainder=pr[N-1:0], div_by_zero=0, ready=1.
  - Go to DONE.
- Latency: ready rises N cycles after the start edge (32 for the default N); throughput is one division per N+2 cycles minimum.
- DONE:
  - Outputs held and ready=1 for as long as enable=1.
  - When enable=0 at an edge: go to IDLE, ready=0; quotient/remainder/div_by_zero keep their values.
  - enable must return low before a new division can start; holding enable high never retriggers.
- dividend/divisor changes during BUSY or DONE are ignored.
- enable dropping during BUSY does not abort; the division completes and ready is asserted.
  - If enable is still low at the first DONE edge, the block returns to IDLE after ready has been high for exactly one cycle.
- Arithmetic invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor.
- quotient, remainder and div_by_zero change only on entry to DONE (or on reset).

Test Plan:
- Basic: reset 1 cycle, dividend=7, divisor=2, enable=1 held 35 cycles -> ready rises exactly 32 cycles after the start edge; quotient=3, remainder=1, div_by_zero=0; ready stays high until enable drops, then low one cycle later; no second start occurs.
- Extremes:
  - 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
  - 0xFFFFFFFF/0xFFFFFFFF -> quotient=1, remainder=0.
  - 10/20 -> quotient=0, remainder=10.
  - 0x80000000/3 -> quotient=0x2AAAAAAA, remainder=2.
- Divide by zero: dividend=5, divisor=0, enable=1 -> ready=1 and div_by_zero=1 after the start edge; quotient=0xFFFFFFFF, remainder=5. A following 9/3 run clears div_by_zero and gives quotient=3, remainder=0.
- Async reset mid-operation: assert reset 10 cycles into a 100/7 division, between clock edges -> ready, quotient, remainder and div_by_zero drop to 0 immediately without a clock edge. A restarted 100/7 run gives quotient=14, remainder=2 after 32 cycles.
- Operand stability: start 1000/10, then change dividend to 0 and divisor to 0 during BUSY -> result is quotient=100, remainder=0, div_by_zero=0.
- Random: 1000 random operand pairs (divisor!=0) checked against a reference model using the invariant; ready latency is 32 on every run.
